// File: rtl/if_queue.sv
// if_queue: circular-buffer decoupling queue between IF/ID and ID.
// Back-pressures IF when full; flush and reset empty it in one edge.
`ifndef WORD_DATA_W
`define WORD_DATA_W 32
`endif
`ifndef ISA_NOP
`define ISA_NOP 32'h0000_0013
`endif

module if_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [`WORD_DATA_W-1:0] if_pc,
  input  logic [`WORD_DATA_W-1:0] if_pc_plus4,
  input  logic [`WORD_DATA_W-1:0] if_insn,
  input  logic                    if_en,
  output logic                    if_stall,
  input  logic                    flush,
  input  logic                    id_stall,
  output logic [`WORD_DATA_W-1:0] q_pc,
  output logic [`WORD_DATA_W-1:0] q_pc_plus4,
  output logic [`WORD_DATA_W-1:0] q_insn,
  output logic                    q_en,
  output logic [PTR_W:0]          q_count
);

  localparam int W = `WORD_DATA_W;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] insn;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign if_stall = (count == FULL);
  assign q_en     = (count != '0);
  assign q_count  = count;
  assign push     = if_en && !if_stall && !flush;
  assign pop      = q_en && !id_stall && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left untouched by reset/flush; only pointers matter.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{pc: if_pc, pc_plus4: if_pc_plus4, insn: if_insn};
    end
  end

  always_comb begin
    head       = mem[rd_ptr];
    q_pc       = '0;
    q_pc_plus4 = '0;
    q_insn     = `ISA_NOP;
    if (q_en) begin
      q_pc       = head.pc;
      q_pc_plus4 = head.pc_plus4;
      q_insn     = head.insn;
    end
  end

endmodule

// File: tb/tb_if_queue.sv
// tb_if_queue: scoreboard bench for if_queue.
// Model FIFO tracks occupancy; consumed heads are logged and compared.
module tb_if_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_pc_plus4 = '0;
  logic [31:0] if_insn = '0;
  logic        if_en = 1'b0;
  logic        if_stall;
  logic        flush = 1'b0;
  logic        id_stall = 1'b0;
  logic [31:0] q_pc;
  logic [31:0] q_pc_plus4;
  logic [31:0] q_insn;
  logic        q_en;
  logic [2:0]  q_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb [$];
  logic [95:0] obs [$];
  logic        s_stall;
  logic [2:0]  s_cnt;

  if_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_insn(if_insn), .if_en(if_en),
    .if_stall(if_stall), .flush(flush),
    .id_stall(id_stall),
    .q_pc(q_pc), .q_pc_plus4(q_pc_plus4),
    .q_insn(q_insn), .q_en(q_en),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_insn(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [95:0] ent(input logic [31:0] pc,
                                      input logic [31:0] insn);
    return {pc, pc + 32'd4, insn};
  endfunction

  // One clock: drive, sample mid-cycle, log DUT consumption, update model.
  task automatic step(input logic en, input logic [31:0] pc,
                      input logic [31:0] insn, input logic ids,
                      input logic fl);
    logic m_pop;
    logic m_push;
    if_en = en;
    if_pc = pc;
    if_pc_plus4 = pc + 32'd4;
    if_insn = insn;
    id_stall = ids;
    flush = fl;
    @(negedge clk);
    s_stall = if_stall;
    s_cnt = q_count;
    if (q_en && !ids && !fl) obs.push_back({q_pc, q_pc_plus4, q_insn});
    if (fl) begin
      sb.delete();
    end else begin
      m_pop = (sb.size() != 0) && !ids;
      m_push = en && (sb.size() != 4);
      if (m_pop) void'(sb.pop_front());
      if (m_push) sb.push_back(pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_en = 1'b0;
    flush = 1'b0;
    id_stall = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    obs.delete();
  endtask

  task automatic test_reset();
    if_en = 1'b1;
    if_pc = 32'h40;
    do_reset();
    checks += 6;
    if (q_en !== 1'b0) begin
      errors++; $display("FAIL reset_q_en got %0b want 0", q_en);
    end
    if (q_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", q_count);
    end
    if (if_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %0b want 0", if_stall);
    end
    if (q_insn !== NOP) begin
      errors++; $display("FAIL reset_insn got %h want %h", q_insn, NOP);
    end
    if (q_pc !== 32'd0) begin
      errors++; $display("FAIL reset_pc got %h want 0", q_pc);
    end
    if (q_pc_plus4 !== 32'd0) begin
      errors++; $display("FAIL reset_pc4 got %h want 0", q_pc_plus4);
    end
  endtask

  task automatic test_stream();
    do_reset();
    step(1'b1, 32'h4, 32'h0c00_8000, 1'b0, 1'b0);
    checks += 4;
    if (q_en !== 1'b1) begin
      errors++; $display("FAIL stream_en1 got %0b want 1", q_en);
    end
    if (q_pc !== 32'h4) begin
      errors++; $display("FAIL stream_pc1 got %h want 4", q_pc);
    end
    if (q_pc_plus4 !== 32'h8) begin
      errors++; $display("FAIL stream_pc4_1 got %h want 8", q_pc_plus4);
    end
    if (q_insn !== 32'h0c00_8000) begin
      errors++; $display("FAIL stream_insn1 got %h want 0c008000", q_insn);
    end
    step(1'b1, 32'h8, 32'h0c21_ffff, 1'b0, 1'b0);
    checks += 4;
    if (q_pc !== 32'h8) begin
      errors++; $display("FAIL stream_pc2 got %h want 8", q_pc);
    end
    if (q_pc_plus4 !== 32'hc) begin
      errors++; $display("FAIL stream_pc4_2 got %h want c", q_pc_plus4);
    end
    if (q_insn !== 32'h0c21_ffff) begin
      errors++; $display("FAIL stream_insn2 got %h want 0c21ffff", q_insn);
    end
    if (q_count !== 3'(sb.size())) begin
      errors++; $display("FAIL stream_count got %0d want %0d", q_count, sb.size());
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks += 2;
    if (q_en !== 1'b0) begin
      errors++; $display("FAIL stream_drain_en got %0b want 0", q_en);
    end
    if (q_insn !== NOP) begin
      errors++; $display("FAIL stream_drain_insn got %h want %h", q_insn, NOP);
    end
  endtask

  task automatic test_fill();
    logic [31:0] pcs [5];
    int idx = 0;
    int seen10 = 0;
    for (int i = 0; i < 5; i++) pcs[i] = 32'(i * 4);
    do_reset();
    for (int c = 0; c < 7; c++) begin
      step(1'b1, pcs[idx], mk_insn(pcs[idx]), 1'b1, 1'b0);
      if (!s_stall && idx < 4) idx++;
    end
    checks += 3;
    if (q_count !== 3'd4) begin
      errors++; $display("FAIL fill_count got %0d want 4", q_count);
    end
    if (if_stall !== 1'b1) begin
      errors++; $display("FAIL fill_stall got %0b want 1", if_stall);
    end
    if (idx !== 4) begin
      errors++; $display("FAIL fill_held got idx %0d want 4", idx);
    end
    for (int c = 0; c < 20 && (idx < 5 || sb.size() != 0); c++) begin
      step(idx < 5, (idx < 5) ? pcs[idx] : 32'h0,
           mk_insn((idx < 5) ? pcs[idx] : 32'h0), 1'b0, 1'b0);
      if (idx < 5 && !s_stall) idx++;
      checks++;
      if (s_cnt > 3'd4) begin
        errors++; $display("FAIL fill_cnt_max got %0d want <=4", s_cnt);
      end
    end
    checks++;
    if (obs.size() !== 5) begin
      errors++; $display("FAIL fill_nout got %0d want 5", obs.size());
    end
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i][95:64] == 32'h10) seen10++;
      if (i < 5) begin
        checks++;
        if (obs[i] !== ent(pcs[i], mk_insn(pcs[i]))) begin
          errors++; $display("FAIL fill_order[%0d] got %h want %h",
                             i, obs[i], ent(pcs[i], mk_insn(pcs[i])));
        end
      end
    end
    checks++;
    if (seen10 !== 1) begin
      errors++; $display("FAIL fill_once got %0d want 1", seen10);
    end
  endtask

  task automatic test_wrap();
    int idx = 0;
    logic ids = 1'b1;
    logic [31:0] pc;
    do_reset();
    for (int c = 0; c < 60 && (idx < 10 || sb.size() != 0); c++) begin
      pc = 32'h100 + 32'(idx * 4);
      step(idx < 10, pc, mk_insn(pc), (idx < 10) ? ids : 1'b0, 1'b0);
      if (idx < 10 && !s_stall) idx++;
      ids = ~ids;
      checks++;
      if (q_count > 3'd4 || q_count !== 3'(sb.size())) begin
        errors++; $display("FAIL wrap_count got %0d want %0d", q_count, sb.size());
      end
    end
    checks++;
    if (obs.size() !== 10) begin
      errors++; $display("FAIL wrap_nout got %0d want 10", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 10; i++) begin
      pc = 32'h100 + 32'(i * 4);
      checks++;
      if (obs[i] !== ent(pc, mk_insn(pc))) begin
        errors++; $display("FAIL wrap_order[%0d] got %h want %h",
                           i, obs[i], ent(pc, mk_insn(pc)));
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h80 + 32'(i * 4), mk_insn(32'h80), 1'b1, 1'b0);
    checks++;
    if (q_count !== 3'd3) begin
      errors++; $display("FAIL flush_pre got %0d want 3", q_count);
    end
    step(1'b1, 32'h20, mk_insn(32'h20), 1'b0, 1'b1);
    checks += 3;
    if (q_en !== 1'b0) begin
      errors++; $display("FAIL flush_en got %0b want 0", q_en);
    end
    if (q_count !== 3'd0) begin
      errors++; $display("FAIL flush_count got %0d want 0", q_count);
    end
    if (if_stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall got %0b want 0", if_stall);
    end
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs.size() !== 0) begin
      errors++; $display("FAIL flush_drop got %0d outputs want 0", obs.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 32'h200, mk_insn(32'h200), 1'b1, 1'b0);
    step(1'b1, 32'h204, mk_insn(32'h204), 1'b1, 1'b0);
    step(1'b1, 32'h208, mk_insn(32'h208), 1'b0, 1'b0);
    checks += 3;
    if (q_count !== 3'd2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", q_count);
    end
    if (q_pc !== 32'h204) begin
      errors++; $display("FAIL b2b_head got %h want 204", q_pc);
    end
    if (obs.size() !== 1 || obs[0] !== ent(32'h200, mk_insn(32'h200))) begin
      errors++; $display("FAIL b2b_pop got %0d items want one 200", obs.size());
    end
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs.size() !== 3 || obs[2] !== ent(32'h208, mk_insn(32'h208))) begin
      errors++; $display("FAIL b2b_tail got %0d items want 3 ending 208", obs.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_fill();
    test_wrap();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_queue.md
# if_queue

Instruction decoupling queue between the IF/ID pipeline register and the ID stage. It buffers up to DEPTH fetched entries {pc, pc_plus4, insn}, so IF can keep fetching while ID is stalled. When the queue fills it back-pressures IF through `if_stall`. It presents the oldest entry to ID with a valid flag, and discards all contents on flush.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- PTR_W, 2, log2(DEPTH)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears queue state
- if_pc  in  `WORD_DATA_W`  PC of the entry presented by IF
- if_pc_plus4  in  `WORD_DATA_W`  PC+4 of the entry presented by IF
- if_insn  in  `WORD_DATA_W`  instruction presented by IF
- if_en  in  1  IF entry valid
- if_stall  out  1  to IF stage `stall`; high holds the IF/ID register
- flush  in  1  discard every queued entry (branch/exception redirect)
- id_stall  in  1  ID cannot consume this cycle
- q_pc  out  `WORD_DATA_W`  PC of oldest entry
- q_pc_plus4  out  `WORD_DATA_W`  PC+4 of oldest entry
- q_insn  out  `WORD_DATA_W`  oldest instruction; `ISA_NOP` when empty
- q_en  out  1  oldest entry valid (queue non-empty)
- q_count  out  PTR_W+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer of {pc, pc_plus4, insn}. Write pointer `wr_ptr` and read pointer `rd_ptr` are PTR_W bits wide and wrap modulo DEPTH. Occupancy `count` is PTR_W+1 bits.
- `if_stall = (count == DEPTH)`. This is combinational from `count` only and has no path from `if_en` or `id_stall`.
- push = `if_en && !if_stall && !flush`. On push, the entry is written at `wr_ptr` and `wr_ptr` increments.
- pop = `q_en && !id_stall && !flush`. On pop, `rd_ptr` increments.
- count next value:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Outputs:
  - q_en = (count != 0).
  - When q_en is high, q_pc, q_pc_plus4 and q_insn read the entry at `rd_ptr` combinationally.
  - When q_en is low, outputs are forced: q_pc = 0, q_pc_plus4 = 0, q_insn = `ISA_NOP`.
- Flush has priority over push and pop:
  - wr_ptr, rd_ptr and count all return to 0 on the next edge.
  - Entry storage is not cleared.
  - An entry presented by IF in the flush cycle is dropped.
- Reset behaves the same as flush and has priority over everything. After reset:
  - q_en = 0, q_count = 0, if_stall = 0
  - q_pc = 0, q_pc_plus4 = 0, q_insn = `ISA_NOP`
- Boundary cases:
  - Empty with push and id_stall low: no pop that cycle, because q_en was 0. The entry becomes visible the next cycle.
  - Full: if_stall is high, so there is no push even when pop occurs. if_stall drops the cycle after the pop.
  - Full with if_en high: IF holds its entry because it is stalled. The queue accepts that same entry exactly once, after the stall drops, so nothing is duplicated or lost.
  - Pointer wrap from DEPTH−1 to 0 must preserve FIFO order.

## Timing
- Latency: an entry pushed at edge N is on q_* with q_en = 1 after edge N (visible in cycle N+1). There is no combinational bypass from the if_* inputs to the q_* outputs.
- Throughput: one push and one pop per cycle sustained. With id_stall low, occupancy stays at 1 in steady state.
- q_* outputs change only after a clock edge.
- if_stall is valid early in each cycle, from the registered count.
- Flush or reset asserted in cycle N: q_en = 0 and if_stall = 0 from cycle N+1.

## Test plan
- Reset: reset = 1 for 2 cycles -> q_en = 0, q_count = 0, if_stall = 0, q_insn = `ISA_NOP`, q_pc = 0.
- Stream: IF presents (pc 0x4, insn 0x0c008000), then (pc 0x8, insn 0x0c21ffff), id_stall = 0 ->
  - cycle after first push: q_pc = 0x4, q_pc_plus4 = 0x8, q_insn = 0x0c008000, q_en = 1
  - next cycle: q_pc = 0x8, q_pc_plus4 = 0xc, q_insn = 0x0c21ffff
- Fill and back-pressure: id_stall = 1, if_en = 1 with pcs 0x0,0x4,0x8,0xc,0x10 ->
  - after 4 pushes: q_count = 4, if_stall = 1
  - IF holds 0x10
  - release id_stall: outputs 0x0,0x4,0x8,0xc,0x10 in order; 0x10 appears exactly once
- Wrap: 10 consecutive entries pushed with id_stall toggling 1/0 each cycle -> output order matches input order across pointer wrap; q_count never exceeds 4.
- Flush: queue holding 3 entries, flush = 1 while if_en = 1 (pc 0x20) -> next cycle q_en = 0, q_count = 0; pc 0x20 never appears on q_pc.
- Simultaneous push/pop at count 2: if_en = 1, id_stall = 0 -> q_count stays 2; head advances to the next-oldest entry.
